divider_seq_core: RTL
=====================

// Module: divider_seq_core
// PURPOSE
// - Multi-cycle unsigned restoring divider core; one quotient bit per clock.
// - Sits directly downstream of the tt_um_unsigned_divider pin front-end: consumes captured
//   {dividend, divisor} operands via valid/ready, produces quotient/remainder via valid/ready.
// - Replaces single-cycle combinational division; bounded area, WIDTH-cycle latency.
// PARAMETERS
// - WIDTH  8  operand/result width in bits (dividend, divisor, quotient, remainder); >= 2
// PORTS
// - clk          in   1      system clock; all state updates on rising edge
// - rst          in   1      synchronous, active-high reset
// - in_valid     in   1      operand pair present
// - in_ready     out  1      core can accept operands (high only in IDLE)
// - dividend     in   WIDTH  unsigned dividend, sampled on in_valid && in_ready
// - divisor      in   WIDTH  unsigned divisor, sampled on in_valid && in_ready
// - out_valid    out  1      result registers hold a finished result
// - out_ready    in   1      consumer takes result
// - quotient     out  WIDTH  unsigned quotient
// - remainder    out  WIDTH  unsigned remainder
// - div_by_zero  out  1      result came from a zero divisor
// - busy         out  1      high in RUN and DONE
// BEHAVIOUR
// - One clock (clk); reset is synchronous and active-high (rst). Reset overrides every other event.
// - Reset values: state=IDLE, in_ready=1 (after the reset cycle), out_valid=0, busy=0,
//   quotient=0, remainder=0, div_by_zero=0, bit counter=0.
// - FSM: IDLE -> RUN (accept, divisor!=0); IDLE -> DONE (accept, divisor==0);
//   RUN -> RUN (count<WIDTH-1); RUN -> DONE (count==WIDTH-1); DONE -> IDLE (out_valid && out_ready).
// - in_ready = (state==IDLE) && !rst, combinational. Inputs ignored whenever in_ready=0.
// - Accept edge: latch divisor, load quotient shift reg with dividend, partial remainder (WIDTH+1 bits)=0,
//   count=0, div_by_zero=0.
// - RUN step per edge: r' = {r[WIDTH-1:0], q[WIDTH-1]}; q <<= 1;
//   if r' >= {1'b0,divisor}: r = r' - divisor, q[0]=1; else r = r', q[0]=0. count++.
// - Latency: accept at edge k -> out_valid visible after edge k+WIDTH (8 cycles at default).
// - Divide by zero: accept at edge k -> DONE after edge k; quotient = all ones, remainder = dividend,
//   div_by_zero=1; out_valid visible after edge k.
// - DONE: quotient/remainder/div_by_zero held stable while out_valid=1 && out_ready=0 (unbounded stall).
// - Output handshake edge: state -> IDLE, out_valid=0; result registers keep last value.
//   No new accept in the same cycle as the output handshake (in_ready=0 in DONE).
// - out_ready while out_valid=0: no effect.
// - Reset mid-RUN or mid-DONE: in-flight operation discarded, no result emitted, reset values apply next cycle.
// - Results exact for all operand pairs: dividend = quotient*divisor + remainder, remainder < divisor.
// STRUCTURE
// - divider_pkg: state enum {IDLE, RUN, DONE}; localparam DIV0_QUOTIENT = all ones (width-generic);
//   counter width function clog2(WIDTH).
// - Sub-module divider_step (combinational): inputs r, next bit, divisor -> r_next, q_bit.
//   Core instantiates one; FSM, counter and registers stay in divider_seq_core.
// - No memories; all outputs registered except in_ready and busy (decoded from state).
// TESTING
// - 10/3 (WIDTH=8), out_ready=1 -> quotient=3, remainder=1, dbz=0; out_valid exactly 8 cycles after accept.
// - 8/2 back-to-back after 10/3 -> quotient=4, remainder=0; in_ready low throughout RUN/DONE of first op.
// - 7/0 -> quotient=8'hFF, remainder=7, div_by_zero=1; out_valid 1 cycle after accept.
// - 255/1 -> 255 r0; 5/200 -> 0 r5; 255/255 -> 1 r0 (boundary operands).
// - 100/7 with out_ready=0 for 5 cycles after out_valid -> 14 r2 held stable, then released; IDLE next cycle.
// - rst=1 at RUN cycle 4 of 200/9 -> next cycle out_valid=0, in_ready=1, quotient=0; following 9/4 -> 2 r1.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
//   div_state_t    : controller states (IDLE, RUN, DONE)
//   DIV0_QUOTIENT  : all-ones quotient reported for a zero divisor; slice to WIDTH
//   div_clog2()    : bit-counter width for a given operand width
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int DIV_MAX_WIDTH = 64;

   // Kept wide so any WIDTH up to DIV_MAX_WIDTH can take its low slice.
   localparam logic [DIV_MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

   // Counter must hold 0..w-1; never narrower than one bit.
   function automatic int div_clog2(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division step, purely combinational.
//   r       in  WIDTH  current partial remainder (always < divisor, so WIDTH bits suffice)
//   bit_in  in  1      next dividend bit shifted in from the quotient register
//   divisor in  WIDTH  divisor
//   r_next  out WIDTH  partial remainder after the trial subtraction
//   q_bit   out 1      quotient bit produced by this step
module divider_step
   import divider_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] r,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] r_next,
   output logic             q_bit
);

   logic [WIDTH:0] r_shift;
   logic [WIDTH:0] divisor_ext;

   assign r_shift     = {r, bit_in};
   assign divisor_ext = {1'b0, divisor};

   always_comb begin
      r_next = r_shift[WIDTH-1:0];
      q_bit  = 1'b0;
      if (r_shift >= divisor_ext) begin
         // Result is below divisor, so the dropped top bit is zero.
         r_next = WIDTH'(r_shift - divisor_ext);
         q_bit  = 1'b1;
      end
   end

endmodule

// File: rtl/divider_seq_core.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      operand handshake; dividend/divisor sampled on acceptance
//   out_valid/out_ready    result handshake; quotient/remainder/div_by_zero held while stalled
//   busy                   high whenever an operation is in flight or waiting to be taken
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// RUN   | shifting out one quotient bit per clock, WIDTH clocks total
// DONE  | result valid, waiting for out_ready
module divider_seq_core
   import divider_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             busy
);

   localparam int CNT_W = div_clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   div_state_t       state;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] r_reg;
   logic [WIDTH-1:0] divisor_reg;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] r_next;
   logic             q_bit;

   divider_step #(.WIDTH(WIDTH)) u_step (
      .r       (r_reg),
      .bit_in  (q_reg[WIDTH-1]),
      .divisor (divisor_reg),
      .r_next  (r_next),
      .q_bit   (q_bit)
   );

   assign in_ready  = (state == IDLE) && !rst;
   assign busy      = (state != IDLE);
   assign quotient  = q_reg;
   assign remainder = r_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         q_reg       <= '0;
         r_reg       <= '0;
         divisor_reg <= '0;
         count       <= '0;
         out_valid   <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  divisor_reg <= divisor;
                  count       <= '0;
                  if (divisor == '0) begin
                     // Zero divisor skips RUN entirely.
                     q_reg       <= DIV0_QUOTIENT[WIDTH-1:0];
                     r_reg       <= dividend;
                     div_by_zero <= 1'b1;
                     out_valid   <= 1'b1;
                     state       <= DONE;
                  end else begin
                     q_reg       <= dividend;
                     r_reg       <= '0;
                     div_by_zero <= 1'b0;
                     state       <= RUN;
                  end
               end
            end
            RUN: begin
               // Quotient register doubles as the dividend shifter.
               r_reg <= r_next;
               q_reg <= {q_reg[WIDTH-2:0], q_bit};
               count <= count + CNT_W'(1);
               if (count == CNT_LAST) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
